// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
// Pin bundle struct lets the controller compute and register all pins as one word.
package sram_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sram_state_e;

  typedef struct packed {
    logic               ce_n;
    logic               we_n;
    logic               oe_n;
    logic               lb_n;
    logic               ub_n;
    logic               dq_oe;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] dq;
  } sram_pins_t;

  localparam sram_pins_t PINS_RESET = '{
    ce_n:  1'b1,
    we_n:  1'b1,
    oe_n:  1'b1,
    lb_n:  1'b1,
    ub_n:  1'b1,
    dq_oe: 1'b0,
    addr:  {SRAM_AW{1'b0}},
    dq:    {SRAM_DW{1'b0}}
  };

endpackage

// File: rtl/sram_wait_cnt.sv
// Phase wait counter: loads WAIT_CYCLES-1 on phase entry, counts down,
// and flags the final cycle of the phase when it reaches zero.
module sram_wait_cnt #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  localparam logic [2:0] LOAD_VAL = 3'(WAIT_CYCLES - 1);

  logic [2:0] cnt_q, cnt_d;

  // Next count: reload wins over decrement, saturate at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == 3'd0);

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage controller mapping 32-bit loads/stores onto a 16-bit SRAM as
// two halfword phases (LO then HI); all SRAM pins and o_rdata are registered.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req,
  input  logic               i_wren,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  input  logic [3:0]         i_bmask,
  output logic [31:0]        o_rdata,
  output logic               o_sram_stall,
  output logic [SRAM_AW-1:0] o_SRAM_ADDR,
  output logic [SRAM_DW-1:0] o_SRAM_DQ,
  input  logic [SRAM_DW-1:0] i_SRAM_DQ,
  output logic               o_SRAM_DQ_OE,
  output logic               o_SRAM_CE_N,
  output logic               o_SRAM_WE_N,
  output logic               o_SRAM_OE_N,
  output logic               o_SRAM_LB_N,
  output logic               o_SRAM_UB_N
);

  sram_state_e state_q, state_d;
  logic        wren_q, wren_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  bmask_q, bmask_d;
  logic [31:0] rdata_q, rdata_d;
  sram_pins_t  pins_q, pins_d;

  logic        cur_wren;
  logic [16:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_bmask;
  logic        phase_hi;
  logic        wc_load, wc_dec, wc_last;
  logic        addr_unused;

  assign addr_unused = ^{i_addr[31:19], i_addr[1:0]};

  sram_wait_cnt #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .load_i (wc_load),
    .dec_i  (wc_dec),
    .last_o (wc_last)
  );

  // Next-state, request latch and load data capture
  always_comb begin
    state_d   = state_q;
    wren_d    = wren_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bmask_d   = bmask_q;
    rdata_d   = rdata_q;
    // In IDLE the request is not latched yet, so pins must see the live inputs
    cur_wren  = wren_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_bmask = bmask_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          wren_d    = i_wren;
          addr_d    = i_addr[18:2];
          wdata_d   = i_wdata;
          bmask_d   = i_bmask;
          cur_wren  = i_wren;
          cur_addr  = i_addr[18:2];
          cur_wdata = i_wdata;
          cur_bmask = i_bmask;
          if (!i_wren) begin
            state_d = LO;
          end else if (i_bmask == 4'b0000) begin
            state_d = DONE;
          end else if (i_bmask[1:0] == 2'b00) begin
            state_d = HI;
          end else begin
            state_d = LO;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        if (wc_last) begin
          if (!wren_q) begin
            rdata_d[15:0] = i_SRAM_DQ;
          end else begin
            rdata_d = rdata_q;
          end
          if (!wren_q || (bmask_q[3:2] != 2'b00)) begin
            state_d = HI;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = LO;
        end
      end
      HI: begin
        if (wc_last) begin
          if (!wren_q) begin
            rdata_d[31:16] = i_SRAM_DQ;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = DONE;
        end else begin
          state_d = HI;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values for the state being entered, so registered pins line up with it
  always_comb begin
    pins_d       = pins_q;
    pins_d.ce_n  = 1'b1;
    pins_d.we_n  = 1'b1;
    pins_d.oe_n  = 1'b1;
    pins_d.lb_n  = 1'b1;
    pins_d.ub_n  = 1'b1;
    pins_d.dq_oe = 1'b0;
    phase_hi     = (state_d == HI);
    if ((state_d == LO) || (state_d == HI)) begin
      pins_d.ce_n = 1'b0;
      pins_d.addr = {cur_addr, phase_hi};
      if (cur_wren) begin
        pins_d.we_n  = 1'b0;
        pins_d.dq_oe = 1'b1;
        pins_d.dq    = phase_hi ? cur_wdata[31:16] : cur_wdata[15:0];
        pins_d.lb_n  = phase_hi ? ~cur_bmask[2] : ~cur_bmask[0];
        pins_d.ub_n  = phase_hi ? ~cur_bmask[3] : ~cur_bmask[1];
      end else begin
        pins_d.oe_n = 1'b0;
        pins_d.lb_n = 1'b0;
        pins_d.ub_n = 1'b0;
      end
    end else begin
      pins_d.ce_n = 1'b1;
    end
  end

  assign wc_load = ((state_d == LO) || (state_d == HI)) && (state_d != state_q);
  assign wc_dec  = (state_q == LO) || (state_q == HI);

  // State, request latch, read data and pin registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      wren_q  <= 1'b0;
      addr_q  <= 17'd0;
      wdata_q <= 32'd0;
      bmask_q <= 4'd0;
      rdata_q <= 32'd0;
      pins_q  <= PINS_RESET;
    end else begin
      state_q <= state_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bmask_q <= bmask_d;
      rdata_q <= rdata_d;
      pins_q  <= pins_d;
    end
  end

  assign o_sram_stall = ((state_q == IDLE) && i_req) || (state_q == LO) || (state_q == HI);
  assign o_rdata      = rdata_q;
  assign o_SRAM_ADDR  = pins_q.addr;
  assign o_SRAM_DQ    = pins_q.dq;
  assign o_SRAM_DQ_OE = pins_q.dq_oe;
  assign o_SRAM_CE_N  = pins_q.ce_n;
  assign o_SRAM_WE_N  = pins_q.we_n;
  assign o_SRAM_OE_N  = pins_q.oe_n;
  assign o_SRAM_LB_N  = pins_q.lb_n;
  assign o_SRAM_UB_N  = pins_q.ub_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: a WAIT_CYCLES=1 instance on a small SRAM
// model, and a WAIT_CYCLES=3 instance fed a bench-driven data bus.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // WAIT_CYCLES = 1 instance
  logic        req = 1'b0, wren = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [3:0]  bmask = 4'd0;
  logic [31:0] rdata;
  logic        stall, dq_oe, ce_n, we_n, oe_n, lb_n, ub_n;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;

  // WAIT_CYCLES = 3 instance
  logic        req3 = 1'b0;
  logic [31:0] addr3 = 32'd0;
  logic [31:0] rdata3;
  logic        stall3, ce3_n;
  logic [17:0] sram_addr3;
  logic [15:0] dq3 = 16'h0000;
  logic [15:0] unused_dq3;
  logic        unused_oe3, unused_we3, unused_oen3, unused_lb3, unused_ub3;

  // SRAM model with a preload port
  logic [15:0] mem [0:255];
  logic        pk_en = 1'b0;
  logic [7:0]  pk_a = 8'd0;
  logic [15:0] pk_d = 16'd0;

  int n_vec = 0;
  int n_err = 0;

  sram_ctrl #(.WAIT_CYCLES(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_wren(wren),
    .i_addr(addr), .i_wdata(wdata), .i_bmask(bmask),
    .o_rdata(rdata), .o_sram_stall(stall),
    .o_SRAM_ADDR(sram_addr), .o_SRAM_DQ(dq_out), .i_SRAM_DQ(dq_in),
    .o_SRAM_DQ_OE(dq_oe), .o_SRAM_CE_N(ce_n), .o_SRAM_WE_N(we_n),
    .o_SRAM_OE_N(oe_n), .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
  );

  sram_ctrl #(.WAIT_CYCLES(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .i_wren(1'b0),
    .i_addr(addr3), .i_wdata(32'd0), .i_bmask(4'b1111),
    .o_rdata(rdata3), .o_sram_stall(stall3),
    .o_SRAM_ADDR(sram_addr3), .o_SRAM_DQ(unused_dq3), .i_SRAM_DQ(dq3),
    .o_SRAM_DQ_OE(unused_oe3), .o_SRAM_CE_N(ce3_n), .o_SRAM_WE_N(unused_we3),
    .o_SRAM_OE_N(unused_oen3), .o_SRAM_LB_N(unused_lb3), .o_SRAM_UB_N(unused_ub3)
  );

  assign dq_in = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (pk_en) begin
      mem[pk_a] <= pk_d;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= dq_out[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= dq_out[15:8];
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pk_en = 1'b1; pk_a = a; pk_d = d;
    @(posedge clk); #1;
    pk_en = 1'b0;
  endtask

  // One access on dut; returns at the DONE cycle's negedge (or on timeout)
  task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] bm, output int stall_n, output int ce_cnt,
                           output int we_cnt, output logic [1:0] bl);
    int cyc;
    @(posedge clk); #1;
    req = 1'b1; wren = wr; addr = a; wdata = wd; bmask = bm;
    stall_n = 0; ce_cnt = 0; we_cnt = 0; bl = 2'b11; cyc = 0;
    @(negedge clk);
    if (stall) stall_n++;
    @(posedge clk); #1;
    req = 1'b0;
    while (cyc < 40) begin
      @(negedge clk);
      if (!ce_n) ce_cnt++;
      if (!we_n) begin we_cnt++; bl = {ub_n, lb_n}; end
      if (stall) stall_n++;
      else break;
      cyc++;
    end
  endtask

  task automatic check_done_pins(input string tag);
    check_vec(tag, {26'd0, ce_n, we_n, oe_n, lb_n, ub_n, dq_oe}, {26'd0, 6'b111110});
  endtask

  int          sn, cc, wc, dn, cyc, k, lo_n, hi_n;
  logic [1:0]  bl;

  initial begin
    // Reset state
    poke(8'd8, 16'hBEEF);
    poke(8'd9, 16'hDEAD);
    poke(8'd17, 16'h7777);
    #1;
    check_vec("rst_rdata", rdata, 32'd0);
    check_vec("rst_pins", {26'd0, ce_n, we_n, oe_n, lb_n, ub_n, dq_oe}, {26'd0, 6'b111110});
    check_vec("rst_addr_dq", {14'd0, sram_addr}, {dq_out, 16'd0} >> 16);
    check_vec("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load, WAIT_CYCLES=1
    do_access(1'b0, 32'h0000_0010, 32'd0, 4'b1111, sn, cc, wc, bl);
    check_vec("ld_stall", sn, 3);
    check_vec("ld_rdata", rdata, 32'hDEAD_BEEF);
    check_vec("ld_ce", cc, 2);
    check_vec("ld_we", wc, 0);
    check_done_pins("ld_done_pins");

    // Full store then read back
    do_access(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b1111, sn, cc, wc, bl);
    check_vec("st_stall", sn, 3);
    check_vec("st_we", wc, 2);
    check_vec("st_m8", {16'd0, mem[8]}, 32'h5678);
    check_vec("st_m9", {16'd0, mem[9]}, 32'h1234);
    check_vec("st_rdata_hold", rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 32'h0000_0013, 32'd0, 4'b0000, sn, cc, wc, bl);
    check_vec("ldback", rdata, 32'h1234_5678);

    // Upper-half-only store
    do_access(1'b1, 32'h0000_0010, 32'hAAAA_BBBB, 4'b1100, sn, cc, wc, bl);
    check_vec("hi_stall", sn, 2);
    check_vec("hi_we", wc, 1);
    check_vec("hi_lbub", {30'd0, bl}, 32'd0);
    check_vec("hi_m8", {16'd0, mem[8]}, 32'h5678);
    check_vec("hi_m9", {16'd0, mem[9]}, 32'hAAAA);
    check_vec("hi_rdata_hold", rdata, 32'h1234_5678);

    // Lower-half-only store, then single byte
    do_access(1'b1, 32'h0000_0020, 32'h9999_4321, 4'b0011, sn, cc, wc, bl);
    check_vec("lo_stall", sn, 2);
    check_vec("lo_m16", {16'd0, mem[16]}, 32'h4321);
    check_vec("lo_m17", {16'd0, mem[17]}, 32'h7777);
    do_access(1'b1, 32'h0000_0020, 32'h0000_00CD, 4'b0001, sn, cc, wc, bl);
    check_vec("byte_lbub", {30'd0, bl}, 32'd2);
    check_vec("byte_m16", {16'd0, mem[16]}, 32'h43CD);

    // Empty mask: no strobes at all
    do_access(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, sn, cc, wc, bl);
    check_vec("nomask_stall", sn, 1);
    check_vec("nomask_ce", cc, 0);
    check_done_pins("nomask_done_pins");

    // Back-to-back load then store with req held high
    @(posedge clk); #1;
    req = 1'b1; wren = 1'b0; addr = 32'h0000_0020; bmask = 4'b1111;
    dn = 0; cyc = 0; cc = 0;
    while ((dn < 2) && (cyc < 40)) begin
      @(negedge clk);
      cyc++;
      if (!ce_n) cc++;
      if (!stall) begin
        dn++;
        if (dn == 1) begin
          check_vec("b2b_ld", rdata, 32'h7777_43CD);
          wren = 1'b1; addr = 32'h0000_0030; wdata = 32'hCAFE_F00D;
        end else begin
          req = 1'b0;
        end
      end
    end
    check_vec("b2b_cycles", cyc, 8);
    check_vec("b2b_ce", cc, 4);
    cc = 0; sn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!ce_n) cc++;
      if (stall) sn++;
    end
    check_vec("b2b_quiet", cc + sn, 0);
    check_vec("b2b_m24", {16'd0, mem[24]}, 32'hF00D);
    check_vec("b2b_m25", {16'd0, mem[25]}, 32'hCAFE);

    // WAIT_CYCLES=3: data must be taken on the last cycle of each phase
    @(posedge clk); #1;
    req3 = 1'b1; addr3 = 32'h0000_0010; dq3 = 16'hFFFF;
    sn = 0; lo_n = 0; hi_n = 0; k = 0;
    @(negedge clk);
    if (stall3) sn++;
    @(posedge clk); #1;
    req3 = 1'b0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      dq3 = (k == 3) ? 16'h5A5A : ((k == 6) ? 16'hC3C3 : 16'hFFFF);
      if (!ce3_n && (sram_addr3 == 18'd8)) lo_n++;
      if (!ce3_n && (sram_addr3 == 18'd9)) hi_n++;
      if (stall3) sn++;
      else break;
    end
    check_vec("w3_stall", sn, 7);
    check_vec("w3_done_cyc", k, 7);
    check_vec("w3_lo_len", lo_n, 3);
    check_vec("w3_hi_len", hi_n, 3);
    check_vec("w3_rdata", rdata3, 32'hC3C3_5A5A);

    // Reset pulse during HI of a load
    @(posedge clk); #1;
    req = 1'b1; wren = 1'b0; addr = 32'h0000_0010;
    @(negedge clk);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_vec("rhi_in_hi", {14'd0, sram_addr}, 32'd9);
    rst_n = 1'b0;
    #1;
    check_vec("rhi_pins", {26'd0, ce_n, we_n, oe_n, lb_n, ub_n, dq_oe}, {26'd0, 6'b111110});
    check_vec("rhi_rdata", rdata, 32'd0);
    req = 1'b1;
    #1;
    check_vec("rhi_stall_req", {31'd0, stall}, 32'd1);
    req = 1'b0;
    #1;
    check_vec("rhi_stall_noreq", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cc = 0; sn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!ce_n) cc++;
      if (stall) sn++;
    end
    check_vec("rhi_no_resume", cc + sn, 0);
    check_vec("rhi_rdata_after", rdata, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
